// File: rtl/eth_st_pkg.sv
// Shared constants and width helpers for the Ethernet streaming adapters.
package eth_st_pkg;

    // Largest input-side ready latency the adapters support.
    localparam int ETH_ST_MAX_RL = 3;

    // Width of one stored beat: {data, error}.
    function automatic int payload_w(input int data_w, input int error_w);
        return data_w + error_w;
    endfunction

    // Pointer width for a FIFO of the given depth (never less than 1 bit).
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/eth_st_timing_adapter_rl_if.sv
// Avalon-ST style beat channel: valid/ready handshake carrying data and error.
interface eth_st_timing_adapter_rl_if #(
    parameter int DATA_W  = 40,
    parameter int ERROR_W = 7
);
    logic               valid;
    logic               ready;
    logic [DATA_W-1:0]  data;
    logic [ERROR_W-1:0] error;

    // Source side of the channel.
    modport master (
        output valid,
        output data,
        output error,
        input  ready
    );

    // Sink side of the channel.
    modport slave (
        input  valid,
        input  data,
        input  error,
        output ready
    );
endinterface

// File: rtl/eth_st_sync_fifo_mem.sv
// Register-array storage for the adapter FIFO: one write port, async read.
module eth_st_sync_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int PW    = 47,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [PW-1:0] rdata
);
    logic [PW-1:0] mem [DEPTH];

    // Store the incoming beat; contents are not reset (payload is don't-care).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/eth_st_timing_adapter_rl.sv
// Ready-latency adapter: accepts an IN_RL source and presents an RL0 source
// with backpressure, absorbing in-flight beats in a small FIFO.
module eth_st_timing_adapter_rl
    import eth_st_pkg::*;
#(
    parameter int DATA_W  = 40,
    parameter int ERROR_W = 7,
    parameter int IN_RL   = 0,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    eth_st_timing_adapter_rl_if.slave  in_st,
    eth_st_timing_adapter_rl_if.master out_st,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       overflow
);
    localparam int PW = payload_w(DATA_W, ERROR_W);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    // in_ready threshold leaves room for the IN_RL+1 beats that may still
    // arrive after the last asserted ready.
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 1 - IN_RL);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    generate
        if (IN_RL < 0 || IN_RL > ETH_ST_MAX_RL || DEPTH < IN_RL + 1) begin : g_bad_cfg
            $error("eth_st_timing_adapter_rl: illegal IN_RL/DEPTH combination");
        end
    endgenerate

    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;
    logic          drop;
    logic [PW-1:0] head;

    // Explicit wrap so non-power-of-two depths stay inside the array.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign out_st.valid = (count != '0);
    assign do_rd        = out_st.valid && out_st.ready;
    // A write at full is still legal when the head leaves in the same cycle.
    assign do_wr        = in_st.valid && ((count != FULL) || do_rd);
    assign drop         = in_st.valid && (count == FULL) && !do_rd;

    assign in_st.ready  = (count <= RDY_MAX);
    assign fill_level   = count;
    assign {out_st.data, out_st.error} = head;

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    eth_st_sync_fifo_mem #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata ({in_st.data, in_st.error}),
        .raddr (rd_ptr),
        .rdata (head)
    );
endmodule

// File: tb/tb_eth_st_timing_adapter_rl.sv
// Scoreboard bench for eth_st_timing_adapter_rl in three configurations:
// A = IN_RL 0 / DEPTH 4, B = IN_RL 2 / DEPTH 4, C = IN_RL 3 / DEPTH 8.
module tb_eth_st_timing_adapter_rl;
    localparam int DW = 40;
    localparam int EW = 7;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eth_st_timing_adapter_rl_if #(.DATA_W(DW), .ERROR_W(EW)) a_in ();
    eth_st_timing_adapter_rl_if #(.DATA_W(DW), .ERROR_W(EW)) a_out ();
    eth_st_timing_adapter_rl_if #(.DATA_W(DW), .ERROR_W(EW)) b_in ();
    eth_st_timing_adapter_rl_if #(.DATA_W(DW), .ERROR_W(EW)) b_out ();
    eth_st_timing_adapter_rl_if #(.DATA_W(DW), .ERROR_W(EW)) c_in ();
    eth_st_timing_adapter_rl_if #(.DATA_W(DW), .ERROR_W(EW)) c_out ();

    logic [2:0] a_fill;
    logic [2:0] b_fill;
    logic [3:0] c_fill;
    logic       a_ovf;
    logic       b_ovf;
    logic       c_ovf;

    eth_st_timing_adapter_rl #(.DATA_W(DW), .ERROR_W(EW), .IN_RL(0), .DEPTH(4)) dut_a (
        .clk(clk), .reset(rst_a), .in_st(a_in), .out_st(a_out),
        .fill_level(a_fill), .overflow(a_ovf)
    );
    eth_st_timing_adapter_rl #(.DATA_W(DW), .ERROR_W(EW), .IN_RL(2), .DEPTH(4)) dut_b (
        .clk(clk), .reset(rst_b), .in_st(b_in), .out_st(b_out),
        .fill_level(b_fill), .overflow(b_ovf)
    );
    eth_st_timing_adapter_rl #(.DATA_W(DW), .ERROR_W(EW), .IN_RL(3), .DEPTH(8)) dut_c (
        .clk(clk), .reset(rst_c), .in_st(c_in), .out_st(c_out),
        .fill_level(c_fill), .overflow(c_ovf)
    );

    logic [DW+EW-1:0] q_a [$];
    logic [DW+EW-1:0] q_b [$];
    logic [DW+EW-1:0] q_c [$];
    logic [DW+EW-1:0] ea;
    logic [DW+EW-1:0] eb;
    logic [DW+EW-1:0] ec;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted output beat is popped and compared.
    always @(negedge clk) begin
        if (!rst_a && a_out.valid === 1'b1 && a_out.ready === 1'b1) begin
            n_vec++;
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL a_out_beat: got %h, expected no beat", {a_out.data, a_out.error});
            end else begin
                ea = q_a.pop_front();
                if ({a_out.data, a_out.error} !== ea) begin
                    n_err++;
                    $display("FAIL a_out_beat: got %h, expected %h", {a_out.data, a_out.error}, ea);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && b_out.valid === 1'b1 && b_out.ready === 1'b1) begin
            n_vec++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL b_out_beat: got %h, expected no beat", {b_out.data, b_out.error});
            end else begin
                eb = q_b.pop_front();
                if ({b_out.data, b_out.error} !== eb) begin
                    n_err++;
                    $display("FAIL b_out_beat: got %h, expected %h", {b_out.data, b_out.error}, eb);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_c && c_out.valid === 1'b1 && c_out.ready === 1'b1) begin
            n_vec++;
            if (q_c.size() == 0) begin
                n_err++;
                $display("FAIL c_out_beat: got %h, expected no beat", {c_out.data, c_out.error});
            end else begin
                ec = q_c.pop_front();
                if ({c_out.data, c_out.error} !== ec) begin
                    n_err++;
                    $display("FAIL c_out_beat: got %h, expected %h", {c_out.data, c_out.error}, ec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r1, r2, r3, cur;
        int   sent;
        int   peak;
        logic [EW-1:0] er;

        a_in.valid = 0; a_in.data = '0; a_in.error = '0; a_out.ready = 0;
        b_in.valid = 0; b_in.data = '0; b_in.error = '0; b_out.ready = 0;
        c_in.valid = 0; c_in.data = '0; c_in.error = '0; c_out.ready = 0;

        // Reset state
        tick(); tick();
        chk("a_rst_out_valid", a_out.valid, 0);
        chk("a_rst_fill", a_fill, 0);
        chk("a_rst_ovf", a_ovf, 0);
        chk("a_rst_in_ready", a_in.ready, 1);
        chk("b_rst_in_ready", b_in.ready, 1);
        chk("c_rst_in_ready", c_in.ready, 1);
        rst_a = 0; rst_b = 0; rst_c = 0;

        // A: 10 back-to-back beats, each visible one cycle after input
        a_out.ready = 1;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) begin
                chk("a_b2b_valid", a_out.valid, 1);
                chk("a_b2b_data", a_out.data, 64'(k - 1));
                chk("a_b2b_fill_le1", (a_fill <= 1), 1);
            end
            if (k <= 10) begin
                a_in.valid = 1; a_in.data = DW'(k); a_in.error = '0;
                q_a.push_back({DW'(k), EW'(0)});
            end else begin
                a_in.valid = 0;
            end
            tick();
        end
        chk("a_b2b_ovf", a_ovf, 0);
        chk("a_b2b_drained", a_fill, 0);

        // A: fill to DEPTH, then simultaneous push/pop at full
        a_out.ready = 0;
        for (int k = 0; k < 4; k++) begin
            a_in.valid = 1; a_in.data = DW'(8'h11 + k); a_in.error = EW'(k);
            q_a.push_back({DW'(8'h11 + k), EW'(k)});
            tick();
        end
        a_in.valid = 0;
        chk("a_full_fill", a_fill, 4);
        chk("a_full_in_ready", a_in.ready, 0);
        a_out.ready = 1; a_in.valid = 1; a_in.data = DW'(8'h15); a_in.error = EW'(5);
        q_a.push_back({DW'(8'h15), EW'(5)});
        tick();
        chk("a_pushpop_fill", a_fill, 4);
        chk("a_pushpop_ovf", a_ovf, 0);

        // A: forced violation, 0xAA must be dropped
        a_out.ready = 0; a_in.valid = 1; a_in.data = DW'(8'hAA); a_in.error = '0;
        tick();
        a_in.valid = 0;
        chk("a_viol_ovf", a_ovf, 1);
        chk("a_viol_fill", a_fill, 4);
        tick(); tick(); tick();
        chk("a_viol_ovf_sticky", a_ovf, 1);
        a_out.ready = 1;
        for (int i = 0; i < 20 && a_fill != 0; i++) tick();
        chk("a_viol_drained", a_fill, 0);
        chk("a_viol_ovf_after_drain", a_ovf, 1);
        chk("a_viol_queue_empty", q_a.size(), 0);

        // A: reset mid-stream with fill_level 3
        a_out.ready = 0;
        for (int k = 0; k < 3; k++) begin
            a_in.valid = 1; a_in.data = DW'(8'h31 + k); a_in.error = '0;
            tick();
        end
        a_in.valid = 0;
        chk("a_mid_fill", a_fill, 3);
        rst_a = 1;
        tick();
        chk("a_mid_rst_valid", a_out.valid, 0);
        chk("a_mid_rst_fill", a_fill, 0);
        chk("a_mid_rst_ovf", a_ovf, 0);
        chk("a_mid_rst_in_ready", a_in.ready, 1);
        q_a.delete();
        rst_a = 0;
        a_in.valid = 1; a_in.data = DW'(8'h77); a_in.error = EW'(7'h2A);
        q_a.push_back({DW'(8'h77), EW'(7'h2A)});
        tick();
        a_in.valid = 0;
        chk("a_post_rst_valid", a_out.valid, 1);
        chk("a_post_rst_data", a_out.data, 64'h77);
        a_out.ready = 1;
        tick(); tick();
        chk("a_post_rst_queue_empty", q_a.size(), 0);

        // B: IN_RL 2 upstream with out_ready held low
        r1 = 0; r2 = 0; sent = 0; peak = 0;
        b_out.ready = 0;
        for (int c = 0; c < 12; c++) begin
            chk("b_in_ready_thresh", b_in.ready, (b_fill <= 1));
            if (int'(b_fill) > peak) peak = int'(b_fill);
            cur = b_in.ready;
            if (r2 && sent < 4) begin
                b_in.valid = 1; b_in.data = DW'(8'hB1 + sent); b_in.error = EW'(sent + 1);
                q_b.push_back({DW'(8'hB1 + sent), EW'(sent + 1)});
                sent++;
            end else begin
                b_in.valid = 0;
            end
            r2 = r1; r1 = cur;
            tick();
        end
        b_in.valid = 0;
        chk("b_sent", sent, 4);
        chk("b_peak_fill", peak, 4);
        chk("b_ovf", b_ovf, 0);
        b_out.ready = 1;
        for (int i = 0; i < 20 && b_fill != 0; i++) tick();
        chk("b_drained", b_fill, 0);
        chk("b_queue_empty", q_b.size(), 0);

        // C: IN_RL 3, DEPTH 8, out_ready toggling, random error bits
        r1 = 0; r2 = 0; r3 = 0; sent = 0;
        c_out.ready = 1;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            cur = c_in.ready;
            if (r3) begin
                er = EW'($urandom);
                c_in.valid = 1; c_in.data = DW'(16'h100 + sent); c_in.error = er;
                q_c.push_back({DW'(16'h100 + sent), er});
                sent++;
            end else begin
                c_in.valid = 0;
            end
            r3 = r2; r2 = r1; r1 = cur;
            tick();
            c_out.ready = ~c_out.ready;
        end
        c_in.valid = 0;
        chk("c_sent", sent, 20);
        c_out.ready = 1;
        for (int i = 0; i < 40 && c_fill != 0; i++) tick();
        chk("c_drained", c_fill, 0);
        chk("c_ovf", c_ovf, 0);
        chk("c_queue_empty", q_c.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
